pwm_duty_ramp_ctrl: RTL and testbench
=====================================

# pwm_duty_ramp_ctrl

Configuration sequencer for the PWM peripheral's `pwm_duty_cycle` input. It ramps the duty value from its current level toward a programmed target in fixed-size steps, and it changes the duty only at PWM period boundaries so no period is ever truncated. Typical uses are soft-start and LED fade. It sits between the register-write path and `pwm_peripheral`. Its `duty_out` drives `pwm_duty_cycle` directly.

## Interface
Parameters: none; all widths are fixed at 8 bits, matching the peripheral's duty range 0..255.

Ports:
- `clk`  in  1  system clock (10 MHz)
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**
- `ena`  in  1  block enable, same meaning as the peripheral's `ena`
- `wr_en`  in  1  one-cycle register write strobe
- `wr_addr`  in  2  register select: 0 TARGET, 1 STEP, 2 INTERVAL, 3 CTRL
- `wr_data`  in  8  write data
- `period_start`  in  1  one-cycle pulse marking the start of each PWM period, sourced from the PWM timebase
- `duty_out`  out  8  current duty value, registered
- `busy`  out  1  high while a ramp is in progress
- `done`  out  1  one-cycle pulse when a ramp or jump completes

## Operation
Registers and their reset values:
- TARGET: reset 0.
- STEP: reset 1; a written 0 is stored as 1.
- INTERVAL: reset 1; a written 0 is stored as 1. Counts PWM periods between steps.
- CTRL: write-only pulse bits; bit0 START, bit1 ABORT, bit2 JUMP. When more than one bit is set, priority is ABORT > JUMP > START.

FSM has two states, IDLE and RAMP. Internal 8-bit `per_cnt` counts periods.
- IDLE, START written:
  - If `duty_out == TARGET`: stay IDLE and pulse `done` next cycle.
  - Otherwise: go to RAMP with `per_cnt = 0`.
- IDLE or RAMP, JUMP written: `duty_out <= TARGET` next cycle, go to IDLE, pulse `done`. JUMP ignores the period boundary.
- RAMP, `period_start` seen: increment `per_cnt`. When `per_cnt + 1 == INTERVAL`, clear `per_cnt` and apply one step:
  - Up (TARGET > duty): if `TARGET - duty <= STEP` then `duty = TARGET`, else `duty + STEP`.
  - Down (TARGET < duty): if `duty - TARGET <= STEP` then `duty = TARGET`, else `duty - STEP`.
  - Compare in 9 bits. `duty_out` never overshoots TARGET and never wraps.
  - If the new duty equals TARGET: go to IDLE and pulse `done` in the same cycle that `duty_out` updates.
- RAMP, ABORT written: go to IDLE, `duty_out` holds its value, no `done`.
- RAMP, START written: clear `per_cnt` and stay in RAMP.
- TARGET written during RAMP: the new value is used at the next step, and direction is re-evaluated then. If the new TARGET equals the current duty, completion occurs at the next step point.
- STEP or INTERVAL written during RAMP: takes effect at the next compare.
- `ena` low: force IDLE and clear `per_cnt`. `duty_out` and the registers hold their values. Writes are still accepted. CTRL writes and `period_start` are ignored.
- `busy` is high exactly when the state is RAMP.

## Timing
- Reset values: `duty_out = 0`, `busy = 0`, `done = 0`; state IDLE; `per_cnt = 0`.
- A register write in cycle N is visible from cycle N+1.
- CTRL START in cycle N gives `busy = 1` in N+1.
- `period_start` in cycle N gives the stepped `duty_out` in N+1; the peripheral samples it for the new period.
- `done` is high for exactly one cycle. It coincides with the final `duty_out` update, or it falls in the cycle after a START with nothing to do.
- Simultaneous ABORT and `period_start`: ABORT wins and no step is applied.
- Simultaneous START and `period_start`: START wins, `per_cnt` is cleared, and that pulse is not counted.
- `rst` mid-ramp: all state returns to reset values on the next edge, including `duty_out = 0`.
- `period_start` pulses while IDLE are ignored.

## Test plan
- Up-ramp: `duty_out=0`; write TARGET=200, STEP=50, INTERVAL=2, then START. Expect `duty_out` 50/100/150/200 after the 2nd/4th/6th/8th `period_start`. `done` pulses with 200; `busy` drops in the same cycle.
- Down-ramp with clamp: duty=200; write TARGET=10, STEP=64, INTERVAL=1, then START. Expect 136, 72, 10 with no underflow, then `done`.
- Abort and boundary: ramp 0→255 with STEP=16. Assert ABORT in the same cycle as the 3rd `period_start`. Expect `duty_out=32` held, `busy=0`, no `done`, and no change on later pulses.
- JUMP and no-op START: JUMP with TARGET=128 gives `duty_out=128` next cycle plus `done`. START with TARGET=128 then gives only a `done` pulse and `busy` stays 0.
- Zero-register handling and retarget: write STEP=0 and INTERVAL=0 (stored as 1). Start 0→5, then rewrite TARGET=2 after the first step. Expect 1, 2, then `done`.
- Reset and enable: `rst` mid-ramp gives all outputs 0 next cycle. `ena` low mid-ramp gives `busy=0` with `duty_out` held. Re-enable followed by START resumes the ramp from the held value.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Register-write, period-boundary and duty/status signals shared between
// the register path, the PWM timebase and the duty ramp controller.
`timescale 1ns/1ps
interface pwm_duty_ramp_ctrl_if;
  logic       ena;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       period_start;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;

  modport master (
    output ena, wr_en, wr_addr, wr_data, period_start,
    input  duty_out, busy, done
  );

  modport slave (
    input  ena, wr_en, wr_addr, wr_data, period_start,
    output duty_out, busy, done
  );
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty ramp sequencer: walks the PWM duty value toward TARGET in STEP-sized
// increments, one step every INTERVAL PWM periods, only at period boundaries.
`timescale 1ns/1ps
module pwm_duty_ramp_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  pwm_duty_ramp_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  localparam logic [1:0] ADDR_TARGET   = 2'd0;
  localparam logic [1:0] ADDR_STEP     = 2'd1;
  localparam logic [1:0] ADDR_INTERVAL = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  state_e     state_q, state_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] per_cnt_q, per_cnt_d;
  logic       done_q, done_d;
  logic [7:0] target_q, step_q, interval_q;

  logic       ctrl_wr_s, start_s, abort_s, jump_s;
  logic [8:0] per_cnt_inc_s;
  logic [7:0] stepped_s;

  // One step toward tgt, clamped so the result never passes tgt or wraps.
  function automatic logic [7:0] step_toward(input logic [7:0] duty,
                                             input logic [7:0] tgt,
                                             input logic [7:0] stp);
    logic [8:0] diff;
    logic [7:0] res;
    if (tgt > duty) begin
      diff = {1'b0, tgt} - {1'b0, duty};
      res  = (diff <= {1'b0, stp}) ? tgt : (duty + stp);
    end else if (tgt < duty) begin
      diff = {1'b0, duty} - {1'b0, tgt};
      res  = (diff <= {1'b0, stp}) ? tgt : (duty - stp);
    end else begin
      diff = 9'd0;
      res  = tgt;
    end
    return res;
  endfunction

  assign ctrl_wr_s     = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
  assign abort_s       = ctrl_wr_s && bus.wr_data[1];
  assign jump_s        = ctrl_wr_s && bus.wr_data[2];
  assign start_s       = ctrl_wr_s && bus.wr_data[0];
  assign per_cnt_inc_s = {1'b0, per_cnt_q} + 9'd1;
  assign stepped_s     = step_toward(duty_q, target_q, step_q);

  // Configuration registers; writes are accepted even while disabled, and a
  // zero STEP/INTERVAL is stored as 1 so the ramp always makes progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q   <= 8'd0;
      step_q     <= 8'd1;
      interval_q <= 8'd1;
    end else if (bus.wr_en) begin
      case (bus.wr_addr)
        ADDR_TARGET:   target_q   <= bus.wr_data;
        ADDR_STEP:     step_q     <= (bus.wr_data == 8'd0) ? 8'd1 : bus.wr_data;
        ADDR_INTERVAL: interval_q <= (bus.wr_data == 8'd0) ? 8'd1 : bus.wr_data;
        default:       ;
      endcase
    end
  end

  // Next-state logic: CTRL writes take priority over a same-cycle period pulse.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    per_cnt_d = per_cnt_q;
    done_d    = 1'b0;
    if (!bus.ena) begin
      state_d   = ST_IDLE;
      per_cnt_d = 8'd0;
    end else if (abort_s) begin
      state_d   = ST_IDLE;
      per_cnt_d = 8'd0;
    end else if (jump_s) begin
      duty_d    = target_q;
      state_d   = ST_IDLE;
      per_cnt_d = 8'd0;
      done_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            if (duty_q == target_q) begin
              done_d = 1'b1;
            end else begin
              state_d   = ST_RAMP;
              per_cnt_d = 8'd0;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RAMP: begin
          if (start_s) begin
            per_cnt_d = 8'd0;
          end else if (bus.period_start) begin
            // >= rather than == so shrinking INTERVAL below the running count
            // steps at the next pulse instead of waiting for the counter to wrap.
            if (per_cnt_inc_s >= {1'b0, interval_q}) begin
              per_cnt_d = 8'd0;
              duty_d    = stepped_s;
              if (stepped_s == target_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_RAMP;
              end
            end else begin
              per_cnt_d = per_cnt_inc_s[7:0];
            end
          end else begin
            per_cnt_d = per_cnt_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          per_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // State, duty and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      duty_q    <= 8'd0;
      per_cnt_q <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      per_cnt_q <= per_cnt_d;
      done_q    <= done_d;
    end
  end

  assign bus.duty_out = duty_q;
  assign bus.busy     = (state_q == ST_RAMP);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Self-checking bench for pwm_duty_ramp_ctrl: expected duty values are queued
// when a ramp is launched and popped as each step appears on duty_out.
`timescale 1ns/1ps
module tb_pwm_duty_ramp_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  pwm_duty_ramp_ctrl_if bus ();
  pwm_duty_ramp_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse();
    bus.period_start = 1'b1;
    tick();
    bus.period_start = 1'b0;
  endtask

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.duty_out !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", bus.duty_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_up_ramp();
    logic [7:0] e;
    logic e_done;
    wr(2'd0, 8'd200); wr(2'd1, 8'd50); wr(2'd2, 8'd2);
    exp_q.push_back(8'd50); exp_q.push_back(8'd100); exp_q.push_back(8'd150); exp_q.push_back(8'd200);
    wr(2'd3, 8'h01);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL up_busy_start: got %b expected 1", bus.busy); end
    for (int p = 1; p <= 8; p++) begin
      pulse();
      if (p % 2 == 0) begin
        e = pop_exp();
        checks++; if (bus.duty_out !== e) begin errors++; $display("FAIL up_duty_p%0d: got %0d expected %0d", p, bus.duty_out, e); end
      end
      e_done = (p == 8);
      checks++; if (bus.done !== e_done) begin errors++; $display("FAIL up_done_p%0d: got %b expected %b", p, bus.done, e_done); end
      checks++; if (bus.busy !== !e_done) begin errors++; $display("FAIL up_busy_p%0d: got %b expected %b", p, bus.busy, !e_done); end
    end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL up_done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_down_ramp();
    logic [7:0] e;
    logic e_done;
    wr(2'd0, 8'd10); wr(2'd1, 8'd64); wr(2'd2, 8'd1);
    exp_q.push_back(8'd136); exp_q.push_back(8'd72); exp_q.push_back(8'd10);
    wr(2'd3, 8'h01);
    for (int p = 1; p <= 3; p++) begin
      pulse();
      e = pop_exp();
      e_done = (p == 3);
      checks++; if (bus.duty_out !== e) begin errors++; $display("FAIL down_duty_p%0d: got %0d expected %0d", p, bus.duty_out, e); end
      checks++; if (bus.done !== e_done) begin errors++; $display("FAIL down_done_p%0d: got %b expected %b", p, bus.done, e_done); end
    end
    pulse();
    checks++; if (bus.duty_out !== 8'd10) begin errors++; $display("FAIL down_hold: got %0d expected 10", bus.duty_out); end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    int dc;
    wr(2'd0, 8'd0); wr(2'd3, 8'h04);
    wr(2'd0, 8'd255); wr(2'd1, 8'd16); wr(2'd2, 8'd1);
    exp_q.push_back(8'd16); exp_q.push_back(8'd32);
    wr(2'd3, 8'h01);
    for (int p = 1; p <= 2; p++) begin
      pulse();
      e = pop_exp();
      checks++; if (bus.duty_out !== e) begin errors++; $display("FAIL abort_duty_p%0d: got %0d expected %0d", p, bus.duty_out, e); end
    end
    bus.period_start = 1'b1;
    wr(2'd3, 8'h02);
    bus.period_start = 1'b0;
    checks++; if (bus.duty_out !== 8'd32) begin errors++; $display("FAIL abort_duty: got %0d expected 32", bus.duty_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    dc = done_cnt;
    pulse(); pulse(); pulse(); tick();
    checks++; if (bus.duty_out !== 8'd32) begin errors++; $display("FAIL abort_hold: got %0d expected 32", bus.duty_out); end
    checks++; if (done_cnt !== dc) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt - dc); end
  endtask

  task automatic test_jump_noop();
    wr(2'd0, 8'd128);
    wr(2'd3, 8'h04);
    checks++; if (bus.duty_out !== 8'd128) begin errors++; $display("FAIL jump_duty: got %0d expected 128", bus.duty_out); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL jump_done: got %b expected 1", bus.done); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL jump_done_width: got %b expected 0", bus.done); end
    wr(2'd3, 8'h01);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL noop_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL noop_busy: got %b expected 0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL noop_done_width: got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL noop_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_zero_regs();
    logic [7:0] e;
    wr(2'd1, 8'd0); wr(2'd2, 8'd0);
    wr(2'd0, 8'd0); wr(2'd3, 8'h04);
    wr(2'd0, 8'd5);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    wr(2'd3, 8'h01);
    pulse();
    e = pop_exp();
    checks++; if (bus.duty_out !== e) begin errors++; $display("FAIL zero_step1: got %0d expected %0d", bus.duty_out, e); end
    wr(2'd0, 8'd2);
    pulse();
    e = pop_exp();
    checks++; if (bus.duty_out !== e) begin errors++; $display("FAIL zero_step2: got %0d expected %0d", bus.duty_out, e); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    wr(2'd2, 8'd2); wr(2'd0, 8'd10);
    wr(2'd3, 8'h01);
    pulse();
    checks++; if (bus.duty_out !== 8'd2) begin errors++; $display("FAIL b2b_first: got %0d expected 2", bus.duty_out); end
    bus.period_start = 1'b1;
    wr(2'd3, 8'h01);
    bus.period_start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
    pulse();
    checks++; if (bus.duty_out !== 8'd2) begin errors++; $display("FAIL b2b_not_counted: got %0d expected 2", bus.duty_out); end
    exp_q.push_back(8'd3);
    pulse();
    checks++; if (bus.duty_out !== exp_q[0]) begin errors++; $display("FAIL b2b_step: got %0d expected %0d", bus.duty_out, exp_q[0]); end
    void'(pop_exp());
  endtask

  task automatic test_reset_enable();
    wr(2'd2, 8'd1); wr(2'd1, 8'd10); wr(2'd0, 8'd100);
    wr(2'd3, 8'h01);
    pulse();
    checks++; if (bus.duty_out !== 8'd13) begin errors++; $display("FAIL en_step: got %0d expected 13", bus.duty_out); end
    bus.ena = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_low_busy: got %b expected 0", bus.busy); end
    pulse();
    wr(2'd3, 8'h01);
    checks++; if (bus.duty_out !== 8'd13) begin errors++; $display("FAIL en_low_hold: got %0d expected 13", bus.duty_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL en_low_start: got %b expected 0", bus.busy); end
    bus.ena = 1'b1;
    wr(2'd3, 8'h01);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL en_resume_busy: got %b expected 1", bus.busy); end
    pulse();
    checks++; if (bus.duty_out !== 8'd23) begin errors++; $display("FAIL en_resume_step: got %0d expected 23", bus.duty_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.duty_out !== 8'd0) begin errors++; $display("FAIL midrst_duty: got %0d expected 0", bus.duty_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
  endtask

  initial begin
    bus.ena = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'd0;
    bus.period_start = 1'b0;
    rst = 1'b1;
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_abort();
    test_jump_noop();
    test_zero_regs();
    test_back_to_back();
    test_reset_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
